alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand/result width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have ports req_valid, input, 2, per-requester request valid; index 0 is the execute stage, index 1 is the branch/address unit.
REQ-005 The block SHALL have port req_ready, output, 2, per-requester accept; a request transfers when valid and ready are both high at a clock edge.
REQ-006 The block SHALL have ports req0_alufn / req1_alufn, input, 4, ALU function code per requester.
REQ-007 The block SHALL have ports req0_a, req0_b, req1_a, req1_b, input, WIDTH, operands per requester.
REQ-008 The block SHALL have ports alu_fn (output, 4), alu_a and alu_b (output, WIDTH), alu_result (input, WIDTH) and alu_zero (input, 1): the shared combinational ALU connection.
REQ-009 The block SHALL have ports resp_valid (output, 1), resp_ready (input, 1), resp_id (output, 1), resp_result (output, WIDTH) and resp_zero (output, 1): the response channel.
REQ-010 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, EXEC and RESP.
- IDLE -> EXEC on acceptance.
- EXEC -> RESP unconditionally.
- RESP -> IDLE when resp_ready=1 and no new acceptance occurs.
- RESP -> EXEC when resp_ready=1 and a new request is accepted in the same cycle.
REQ-012 req_ready SHALL be asserted only in IDLE, or in RESP with resp_ready=1, and only for the single granted index; at most one bit is high.
REQ-013 Arbitration SHALL be round-robin.
- Only one requester valid: grant it.
- Both valid: grant the index not granted last.
- Last-grant pointer resets to 1, so requester 0 wins the first contention.
- The pointer updates only on an accepted transfer.
REQ-014 On acceptance, the block SHALL register the granted alufn, a, b and index; later changes on req inputs SHALL NOT affect the operation in flight.
REQ-015 In EXEC, alu_fn/alu_a/alu_b SHALL be driven from the registered operands; in all other states they SHALL be 0.
REQ-016 At the end of EXEC, the block SHALL capture alu_result and alu_zero into resp_result and resp_zero.
REQ-017 Latency SHALL be as follows:
- Acceptance at edge N; EXEC during cycle N+1; resp_valid high from cycle N+2.
- Peak throughput is one operation per 2 cycles.
REQ-018 resp_valid SHALL be high only in RESP.
- resp_result, resp_zero and resp_id SHALL hold stable until resp_valid and resp_ready are both high.
- Backpressure is unlimited; requests are not accepted while RESP is stalled.
REQ-019 alufn codes SHALL pass through unmodified; undefined codes are the ALU's concern, not the arbiter's.
REQ-020 A requester dropping req_valid before acceptance SHALL lose no state and SHALL NOT alter the round-robin pointer.

Reset
REQ-021 On rst_n low, the block SHALL asynchronously force:
- state=IDLE, pointer=1;
- req_ready=0, resp_valid=0, resp_id=0, resp_result=0, resp_zero=0;
- alu_fn/alu_a/alu_b=0, busy=0.
REQ-022 Reset during EXEC or RESP SHALL discard the in-flight operation with no response emitted.
REQ-023 Reset release SHALL be synchronized externally; the first acceptance is possible on the first edge with rst_n high.

Structure
REQ-024 The shared defines package SHALL hold the state encodings (IDLE/EXEC/RESP) and the 4-bit ALU function width constant; ALU function codes SHALL be reused from it, not redefined.
REQ-025 One sub-module, rr_arb2, SHALL implement the 2-way round-robin grant and pointer (inputs: valid[1:0], advance; output: grant[1:0]).
REQ-026 The ALU SHALL remain external; the arbiter contains no arithmetic.

Verification
REQ-027 Single request: req_valid=01, ADD, a=5, b=7, resp_ready=1 -> resp_valid at N+2, resp_result=12, resp_id=0, resp_zero=0.
REQ-028 Contention: req_valid=11 held, both SUB, a=b=3 -> grants alternate 0,1,0,1 starting with 0; each response has resp_result=0, resp_zero=1 and a matching resp_id.
REQ-029 Backpressure: resp_ready=0 for 5 cycles after resp_valid -> response held stable, req_ready=00 throughout, and acceptance occurs on the cycle resp_ready rises.
REQ-030 Back-to-back: continuous requests with resp_ready=1 -> one response every 2 cycles, with no lost or duplicated responses.
REQ-031 Operand stability: change req0_a the cycle after acceptance -> the result reflects the originally accepted value.
REQ-032 Reset mid-EXEC: assert rst_n=0 asynchronously -> resp_valid never rises for that operation, all outputs are 0, and the next contention grants requester 0.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: FSM states, function width and ALU codes.
package alu_arbiter_pkg;

    localparam int unsigned ALUFN_W = 4;
    localparam int unsigned NUM_REQ = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // ALU function codes; the arbiter forwards them untouched.
    localparam logic [ALUFN_W-1:0] ALUFN_ADD = 4'h0;
    localparam logic [ALUFN_W-1:0] ALUFN_SUB = 4'h1;
    localparam logic [ALUFN_W-1:0] ALUFN_AND = 4'h2;
    localparam logic [ALUFN_W-1:0] ALUFN_OR  = 4'h3;
    localparam logic [ALUFN_W-1:0] ALUFN_XOR = 4'h4;
    localparam logic [ALUFN_W-1:0] ALUFN_SLT = 4'h5;
    localparam logic [ALUFN_W-1:0] ALUFN_SLL = 4'h6;
    localparam logic [ALUFN_W-1:0] ALUFN_SRL = 4'h7;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant; the pointer remembers the last accepted index.
module rr_arb2
    import alu_arbiter_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       valid,
    input  logic                     advance,
    output logic [NUM_REQ-1:0]       grant
);

    logic last_q;

    // Grant the lone requester, or the one not served last on contention.
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Pointer moves only when a granted request actually transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (advance) begin
            last_q <= grant[1];
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one external combinational ALU, one op at a time.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [ALUFN_W-1:0]   req0_alufn,
    input  logic [ALUFN_W-1:0]   req1_alufn,
    input  logic [WIDTH-1:0]     req0_a,
    input  logic [WIDTH-1:0]     req0_b,
    input  logic [WIDTH-1:0]     req1_a,
    input  logic [WIDTH-1:0]     req1_b,
    output logic [ALUFN_W-1:0]   alu_fn,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    input  logic [WIDTH-1:0]     alu_result,
    input  logic                 alu_zero,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 resp_id,
    output logic [WIDTH-1:0]     resp_result,
    output logic                 resp_zero,
    output logic                 busy
);

    state_t               state_q;
    state_t               state_d;
    logic [NUM_REQ-1:0]   grant;
    logic                 can_accept;
    logic                 accept;
    logic                 op_id_q;
    logic [ALUFN_W-1:0]   sel_fn;
    logic [WIDTH-1:0]     sel_a;
    logic [WIDTH-1:0]     sel_b;

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid   (req_valid),
        .advance (accept),
        .grant   (grant)
    );

    // Operand mux for the granted requester.
    always_comb begin
        sel_fn = grant[1] ? req1_alufn : req0_alufn;
        sel_a  = grant[1] ? req1_a     : req0_a;
        sel_b  = grant[1] ? req1_b     : req0_b;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake; a new op may enter while the old response drains.
    always_comb begin
        state_d    = state_q;
        can_accept = 1'b0;
        accept     = 1'b0;
        req_ready  = 2'b00;
        case (state_q)
            ST_IDLE: begin
                can_accept = 1'b1;
            end
            ST_RESP: begin
                can_accept = resp_ready;
            end
            default: begin
                can_accept = 1'b0;
            end
        endcase
        if (can_accept && rst_n) begin
            req_ready = grant;
        end
        accept = |(req_valid & req_ready);
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = accept ? ST_EXEC : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Operand capture drives the ALU for exactly the EXEC cycle; result captured at its end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_fn      <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            op_id_q     <= 1'b0;
            resp_id     <= 1'b0;
            resp_result <= '0;
            resp_zero   <= 1'b0;
        end else begin
            alu_fn <= accept ? sel_fn : '0;
            alu_a  <= accept ? sel_a  : '0;
            alu_b  <= accept ? sel_b  : '0;
            if (accept) begin
                op_id_q <= grant[1];
            end
            if (state_q == ST_EXEC) begin
                resp_id     <= op_id_q;
                resp_result <= alu_result;
                resp_zero   <= alu_zero;
            end
        end
    end

    // Status flags decoded straight from the state register.
    always_comb begin
        resp_valid = (state_q == ST_RESP);
        busy       = (state_q != ST_IDLE);
    end

endmodule
